// File: rtl/fp_mul_round_pkg.sv
// Shared widths, constants, flag indices and the stage-1 register layout
// for the floating-point multiplier normalize/round/pack stage.
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_PROD_W = 48;
  localparam int FP_E_W    = 10;
  localparam int FP_FLAG_W = 4;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Working exponent: wide and signed so overflow/underflow survive to stage 2.
  typedef logic signed [FP_E_W-1:0] fp_exp_t;

  typedef struct packed {
    logic                 sign;
    fp_exp_t              e;
    logic [FP_MANT_W-1:0] mant;
    logic                 guard;
    logic                 sticky;
    logic                 a_zero;
    logic                 a_inf;
    logic                 b_zero;
    logic                 b_inf;
  } fp_s1_t;

endpackage

// File: rtl/fp_mul_round_if.sv
// Valid/ready bundle between the multiplier datapath, this stage and its consumer.
interface fp_mul_round_if;
  import fp_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [FP_EXP_W-1:0]  in_exp_a;
  logic [FP_EXP_W-1:0]  in_exp_b;
  logic [FP_PROD_W-1:0] in_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [FP_FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_sign, in_exp_a, in_exp_b, in_prod, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp_a, in_exp_b, in_prod, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_mul_round_rne.sv
// Combinational mantissa rounding. FP_RNE_EN selects round-to-nearest-even;
// without it the mantissa is truncated but inexact is still reported.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  fp_exp_t              e,
  output logic [FP_MANT_W-1:0] mant_rnd,
  output fp_exp_t              e_rnd,
  output logic                 inexact
);

  logic               round_up;
  logic [FP_MANT_W:0] mant_inc;

`ifdef FP_RNE_EN
  assign round_up = guard & (sticky | mant[0]);
`else
  assign round_up = 1'b0;
`endif

  assign mant_inc = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
  assign mant_rnd = mant_inc[FP_MANT_W-1:0];
  // Carry out of the fraction means 1.111..1 rounded up to 10.000..0.
  assign e_rnd    = e + fp_exp_t'({{(FP_E_W-1){1'b0}}, mant_inc[FP_MANT_W]});
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_mul_round.sv
// Two-stage valid/ready normalize then round/pack of a 48-bit mantissa product
// into an IEEE single with flags. Rounding mode selected by FP_RNE_EN.
module fp_mul_round
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp_mul_round_if.slave bus
);

  localparam fp_exp_t E_ONE  = fp_exp_t'(1);
  localparam fp_exp_t E_ZERO = fp_exp_t'(0);
  localparam fp_exp_t E_MAX  = fp_exp_t'((1 << FP_EXP_W) - 1);
  localparam fp_exp_t E_BIAS = fp_exp_t'(FP_BIAS);
  localparam logic [FP_EXP_W-1:0] EXP_ALL1 = {FP_EXP_W{1'b1}};

  fp_s1_t               s1_next;
  fp_s1_t               s1_reg;
  logic                 s1_valid_reg;
  logic                 s2_valid_reg;
  logic [31:0]          result_next;
  logic [31:0]          result_reg;
  logic [FP_FLAG_W-1:0] flags_next;
  logic [FP_FLAG_W-1:0] flags_reg;

  logic    s1_advance;
  logic    s2_advance;
  logic    in_fire;
  fp_exp_t e_sum;

  logic [FP_MANT_W-1:0] mant_rnd;
  fp_exp_t              e_rnd;
  logic                 rnd_inexact;

  assign s2_advance  = s2_valid_reg & bus.out_ready;
  assign s1_advance  = s1_valid_reg & (~s2_valid_reg | s2_advance);
  assign bus.in_ready = ~s1_valid_reg | s1_advance;
  assign in_fire     = bus.in_valid & bus.in_ready;

  assign e_sum = fp_exp_t'({2'b00, bus.in_exp_a}) + fp_exp_t'({2'b00, bus.in_exp_b}) - E_BIAS;

  // Stage 1: pick the normalization window on the product's top bit.
  always_comb begin
    s1_next        = '0;
    s1_next.sign   = bus.in_sign;
    if (bus.in_prod[FP_PROD_W-1]) begin
      s1_next.mant   = bus.in_prod[46:24];
      s1_next.guard  = bus.in_prod[23];
      s1_next.sticky = |bus.in_prod[22:0];
      s1_next.e      = e_sum + E_ONE;
    end else begin
      s1_next.mant   = bus.in_prod[45:23];
      s1_next.guard  = bus.in_prod[22];
      s1_next.sticky = |bus.in_prod[21:0];
      s1_next.e      = e_sum;
    end
    s1_next.a_zero = (bus.in_exp_a == '0);
    s1_next.a_inf  = (bus.in_exp_a == EXP_ALL1);
    s1_next.b_zero = (bus.in_exp_b == '0);
    s1_next.b_inf  = (bus.in_exp_b == EXP_ALL1);
  end

  fp_round_rne u_round (
    .mant     (s1_reg.mant),
    .guard    (s1_reg.guard),
    .sticky   (s1_reg.sticky),
    .e        (s1_reg.e),
    .mant_rnd (mant_rnd),
    .e_rnd    (e_rnd),
    .inexact  (rnd_inexact)
  );

  // Stage 2: specials first, then range checks on the rounded exponent.
  always_comb begin
    result_next = '0;
    flags_next  = '0;
    if ((s1_reg.a_inf & s1_reg.b_zero) | (s1_reg.b_inf & s1_reg.a_zero)) begin
      result_next              = FP_QNAN;
      flags_next[FLAG_INVALID] = 1'b1;
    end else if (s1_reg.a_inf | s1_reg.b_inf) begin
      result_next = {s1_reg.sign, EXP_ALL1, {FP_MANT_W{1'b0}}};
    end else if (s1_reg.a_zero | s1_reg.b_zero) begin
      result_next = {s1_reg.sign, {(FP_EXP_W + FP_MANT_W){1'b0}}};
    end else if (e_rnd >= E_MAX) begin
      result_next               = {s1_reg.sign, EXP_ALL1, {FP_MANT_W{1'b0}}};
      flags_next[FLAG_OVERFLOW] = 1'b1;
      flags_next[FLAG_INEXACT]  = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      result_next                = {s1_reg.sign, {(FP_EXP_W + FP_MANT_W){1'b0}}};
      flags_next[FLAG_UNDERFLOW] = 1'b1;
      flags_next[FLAG_INEXACT]   = 1'b1;
    end else begin
      result_next              = {s1_reg.sign, e_rnd[FP_EXP_W-1:0], mant_rnd};
      flags_next[FLAG_INEXACT] = rnd_inexact;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
      flags_reg    <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid_reg <= bus.in_valid;
      end
      if (!s2_valid_reg || s2_advance) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (s1_advance) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_reg <= s1_next;
    end
  end

  // Outputs read zero whenever nothing is presented, including during reset.
  assign bus.out_valid  = s2_valid_reg;
  assign bus.out_result = s2_valid_reg ? result_reg : '0;
  assign bus.out_flags  = s2_valid_reg ? flags_reg  : '0;

endmodule

// File: tb/tb_fp_mul_round.sv
// Self-checking bench for fp_mul_round: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_fp_mul_round;
  import fp_pkg::*;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] result;
  } exp_t;

  typedef struct {
    string       tag;
    logic        s;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] p;
    logic [31:0] res;
    logic [3:0]  fl;
  } dir_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mul_round_if bus ();

  fp_mul_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   out_cnt      = 0;
  exp_t sb_q[$];
  dir_t dirs[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: treat the product as a fixed-point significand and round by remainder.
  function automatic exp_t model(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [47:0] p);
    exp_t            r;
    int              e;
    int              sh;
    longint unsigned sig;
    longint unsigned rem;
    longint unsigned half;
    bit              up;
    r = '0;
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) begin
      r.result = 32'h7FC0_0000;
      r.flags  = 4'b1000;
      return r;
    end
    if (ea == 8'hFF || eb == 8'hFF) begin
      r.result = {s, 8'hFF, 23'h0};
      return r;
    end
    if (ea == 8'h00 || eb == 8'h00) begin
      r.result = {s, 31'h0};
      return r;
    end
    sh   = p[47] ? 24 : 23;
    e    = int'(ea) + int'(eb) - 127 + (p[47] ? 1 : 0);
    sig  = 64'(p) >> sh;
    rem  = 64'(p) & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
`ifdef FP_RNE_EN
    up = (rem > half) || (rem == half && sig[0]);
`else
    up = 1'b0;
`endif
    if (up) sig = sig + 64'd1;
    if (sig >= (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) begin
      r.result = {s, 8'hFF, 23'h0};
      r.flags  = 4'b0101;
    end else if (e <= 0) begin
      r.result = {s, 31'h0};
      r.flags  = 4'b0011;
    end else begin
      r.result = {s, e[7:0], sig[22:0]};
      r.flags  = {3'b000, rem != 64'd0};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("model_result", bus.out_result, e.result);
        check_val("model_flags", bus.out_flags, e.flags);
      end
      $display("[TB] out #%0d result=%08h flags=%04b", out_cnt, bus.out_result, bus.out_flags);
      out_cnt++;
    end
    if (rst && bus.in_valid && bus.in_ready)
      sb_q.push_back(model(bus.in_sign, bus.in_exp_a, bus.in_exp_b, bus.in_prod));
  end

  task automatic add_dir(input string tag, input logic s, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [47:0] p, input logic [31:0] res, input logic [3:0] fl);
    dir_t d;
    d.tag = tag; d.s = s; d.ea = ea; d.eb = eb; d.p = p; d.res = res; d.fl = fl;
    dirs.push_back(d);
  endtask

  task automatic send(input logic s, input logic [7:0] ea, input logic [7:0] eb, input logic [47:0] p);
    bit ok = 1'b0;
    bus.in_sign  = s;
    bus.in_exp_a = ea;
    bus.in_exp_b = eb;
    bus.in_prod  = p;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check_val("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] res, input logic [3:0] fl);
    int lat  = 1;
    bit seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, seen ? lat : 0, 64'd2);
    check_val({tag, "_result"}, bus.out_result, res);
    check_val({tag, "_flags"}, bus.out_flags, fl);
    @(posedge clk); #1;
  endtask

  task automatic drive_bp(input int i);
    if (i < 4) begin
      bus.in_sign  = i[0];
      bus.in_exp_a = 8'(100 + i * 10);
      bus.in_exp_b = 8'd127;
      bus.in_prod  = 48'hA000_0000_0000;
      bus.in_valid = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    int          bp_idx;
    int          cnt0;
    int          nsent;
    bit          fire;
    logic [31:0] hold_res;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [7:0]  ex[2];

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp_a  = '0;
    bus.in_exp_b  = '0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 64'd0);
    check_val("rst_out_result", bus.out_result, 64'd0);
    check_val("rst_out_flags", bus.out_flags, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("ready_after_reset", bus.in_ready, 64'd1);
    @(posedge clk); #1;

    add_dir("norm",      1'b0, 8'd127, 8'd127, 48'h9000_0000_0000, 32'h4010_0000, 4'b0000);
    add_dir("tie_even",  1'b0, 8'd127, 8'd127, 48'h4000_0040_0000, 32'h3F80_0000, 4'b0001);
`ifdef FP_RNE_EN
    add_dir("tie_odd",   1'b0, 8'd127, 8'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 4'b0001);
    add_dir("carry",     1'b0, 8'd127, 8'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 4'b0001);
`else
    add_dir("tie_odd",   1'b0, 8'd127, 8'd127, 48'h4000_00C0_0000, 32'h3F80_0001, 4'b0001);
    add_dir("carry",     1'b0, 8'd127, 8'd127, 48'h7FFF_FFC0_0000, 32'h3FFF_FFFF, 4'b0001);
`endif
    add_dir("overflow",  1'b1, 8'd200, 8'd200, 48'h8000_0000_0000, 32'hFF80_0000, 4'b0101);
    add_dir("underflow", 1'b0, 8'd10,  8'd10,  48'h8000_0000_0000, 32'h0000_0000, 4'b0011);
    add_dir("invalid",   1'b0, 8'd255, 8'd0,   48'h8000_0000_0000, 32'h7FC0_0000, 4'b1000);
    add_dir("inf",       1'b1, 8'd255, 8'd127, 48'h8000_0000_0000, 32'hFF80_0000, 4'b0000);
    add_dir("zero",      1'b1, 8'd0,   8'd127, 48'h8000_0000_0000, 32'h8000_0000, 4'b0000);
    add_dir("e_255",     1'b0, 8'd254, 8'd128, 48'h4000_0000_0000, 32'h7F80_0000, 4'b0101);
    add_dir("e_254",     1'b0, 8'd254, 8'd127, 48'h4000_0000_0000, 32'h7F00_0000, 4'b0000);
    add_dir("e_1",       1'b0, 8'd1,   8'd127, 48'h4000_0000_0000, 32'h0080_0000, 4'b0000);
    add_dir("e_0",       1'b0, 8'd1,   8'd126, 48'h4000_0000_0000, 32'h0000_0000, 4'b0011);

    foreach (dirs[i]) begin
      send(dirs[i].s, dirs[i].ea, dirs[i].eb, dirs[i].p);
      expect_result(dirs[i].tag, dirs[i].res, dirs[i].fl);
    end

    // Backpressure: stall the output and let the pipeline fill.
    bus.out_ready = 1'b0;
    bp_idx   = 0;
    hold_res = '0;
    for (int c = 0; c < 6; c++) begin
      drive_bp(bp_idx);
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (c == 2) hold_res = bus.out_result;
      @(posedge clk); #1;
      if (fire) bp_idx++;
    end
    @(negedge clk);
    check_val("bp_accepts", bp_idx, 64'd2);
    check_val("bp_in_ready", bus.in_ready, 64'd0);
    check_val("bp_out_valid", bus.out_valid, 64'd1);
    check_val("bp_hold", bus.out_result, hold_res);
    @(posedge clk); #1;
    cnt0 = out_cnt;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_bp(bp_idx);
      @(negedge clk);
      check_val("bp_stream", bus.out_valid, 64'd1);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) bp_idx++;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("bp_all_sent", bp_idx, 64'd4);
    check_val("bp_out_count", out_cnt - cnt0, 64'd4);
    check_val("bp_sb_empty", sb_q.size(), 64'd0);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    send(1'b0, 8'd127, 8'd127, 48'h9000_0000_0000);
    send(1'b1, 8'd130, 8'd127, 48'h9000_0000_0000);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_out_valid", bus.out_valid, 64'd0);
    check_val("midrst_out_result", bus.out_result, 64'd0);
    check_val("midrst_out_flags", bus.out_flags, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cnt0 = out_cnt;
    send(1'b0, 8'd128, 8'd127, 48'h9000_0000_0000);
    expect_result("post_rst", 32'h4090_0000, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_count", out_cnt - cnt0, 64'd1);

    // Randomized traffic with random output stalls.
    cnt0  = out_cnt;
    nsent = 0;
    for (int c = 0; c < 4000 && nsent < 300; c++) begin
      bus.out_ready = ($urandom % 4) != 0;
      if (!bus.in_valid && ($urandom % 3) != 0) begin
        for (int k = 0; k < 2; k++) begin
          case ($urandom % 16)
            0:       ex[k] = 8'd0;
            1:       ex[k] = 8'd255;
            2, 3:    ex[k] = 8'($urandom_range(0, 255));
            default: ex[k] = 8'($urandom_range(60, 190));
          endcase
        end
        ma = $urandom_range(0, 32'h7F_FFFF);
        mb = $urandom_range(0, 32'h7F_FFFF);
        mb = mb & ~((32'd1 << $urandom_range(0, 23)) - 32'd1);
        bus.in_sign  = 1'($urandom % 2);
        bus.in_exp_a = ex[0];
        bus.in_exp_b = ex[1];
        bus.in_prod  = 48'({1'b1, ma[22:0]}) * 48'({1'b1, mb[22:0]});
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) begin
        nsent++;
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("rand_sent", nsent, 64'd300);
    check_val("rand_out_count", out_cnt - cnt0, nsent);
    check_val("rand_sb_empty", sb_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
